pipe_ctrl: RTL and testbench

- Sequences the five-stage pipeline (IF, ID, EX, MEM, WB) from program start to drain.
- Tracks per-stage instruction validity and drives per-stage enables.
- Detects load-use hazards: stalls IF/ID and inserts an EX bubble.
- On a taken branch, flushes the two younger stages.
- Sits beside the stage modules in `main`, replaces the stub operation-control block, and drives the fetch unit's `hazard` input.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl_hazard.sv | 31 +++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } pipe_state_t;

    localparam int ST_IF      = 0;
    localparam int ST_ID      = 1;
    localparam int ST_EX      = 2;
    localparam int ST_MEM     = 3;
    localparam int ST_WB      = 4;
    localparam int NUM_STAGES = 5;

    // Stall counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    import pipe_pkg::*;

    logic                  valid;
    logic                  opr_finished;
    logic [REG_AW-1:0]     id_rs;
    logic [REG_AW-1:0]     id_rt;
    logic                  ex_mem_read;
    logic [REG_AW-1:0]     ex_rt;
    logic                  ex_branch_taken;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  flush_ifid;
    logic                  flush_idex;
    logic                  hazard;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [15:0]           stall_cnt;

    modport master (
        output valid, opr_finished, id_rs, id_rt, ex_mem_read, ex_rt, ex_branch_taken,
        input  stage_en, flush_ifid, flush_idex, hazard, busy, done, cycle_cnt, stall_cnt
    );

    modport slave (
        input  valid, opr_finished, id_rs, id_rt, ex_mem_read, ex_rt, ex_branch_taken,
        output stage_en, flush_ifid, flush_idex, hazard, busy, done, cycle_cnt, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Combinational hazard detection: load-use between EX and ID, and taken branch in EX.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              vld_id,
    input  logic              vld_ex,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_branch_taken,
    output logic              ld_use,
    output logic              br
);

    // Register 0 is never a real dependency, so a load to it cannot stall.
    always_comb begin
        ld_use = 1'b0;
        br     = 1'b0;
        if (vld_id && vld_ex && ex_mem_read && (ex_rt != {REG_AW{1'b0}}) &&
            ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
            ld_use = 1'b1;
        end else begin
            ld_use = 1'b0;
        end
        br = vld_ex & ex_branch_taken;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline operation controller: sequences IF..WB from start to drain, tracks
// per-stage validity and resolves load-use stalls and taken-branch flushes.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);

    pipe_state_t             state_q;
    pipe_state_t             state_d;
    logic [NUM_STAGES-1:1]   vld_q;
    logic [NUM_STAGES-1:1]   vld_d;
    logic [NUM_STAGES-1:0]   vld_s;
    logic [NUM_STAGES-1:0]   stage_en_s;
    logic [CNT_W-1:0]        cycle_cnt_q;
    logic [CNT_W-1:0]        cycle_cnt_d;
    logic [15:0]             stall_cnt_q;
    logic [15:0]             stall_cnt_d;
    logic                    ld_use_s;
    logic                    br_s;
    logic                    hazard_s;
    logic                    busy_s;
    logic                    start_s;

    // IF validity is not stored: a fetch happens on every RUN cycle.
    assign vld_s    = {vld_q, (state_q == RUN)};
    assign hazard_s = ld_use_s & ~br_s;
    assign busy_s   = (state_q == RUN) || (state_q == DRAIN);

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .vld_id          (vld_s[ST_ID]),
        .vld_ex          (vld_s[ST_EX]),
        .id_rs           (bus.id_rs),
        .id_rt           (bus.id_rt),
        .ex_mem_read     (bus.ex_mem_read),
        .ex_rt           (bus.ex_rt),
        .ex_branch_taken (bus.ex_branch_taken),
        .ld_use          (ld_use_s),
        .br              (br_s)
    );

    // Stage enables and validity advance; a branch squashes ID/EX, a stall holds ID and bubbles EX.
    always_comb begin
        stage_en_s        = vld_s;
        stage_en_s[ST_IF] = vld_s[ST_IF] & ~hazard_s;
        stage_en_s[ST_ID] = vld_s[ST_ID] & ~hazard_s;
        vld_d             = vld_q;
        vld_d[ST_MEM]     = vld_s[ST_EX];
        vld_d[ST_WB]      = vld_s[ST_MEM];
        if (br_s) begin
            vld_d[ST_ID] = 1'b0;
            vld_d[ST_EX] = 1'b0;
        end else if (hazard_s) begin
            vld_d[ST_ID] = vld_s[ST_ID];
            vld_d[ST_EX] = 1'b0;
        end else begin
            vld_d[ST_ID] = vld_s[ST_IF];
            vld_d[ST_EX] = vld_s[ST_ID];
        end
    end

    // Sequencing; a stalled cycle leaves opr_finished pending so the fetch unit re-presents it.
    always_comb begin
        state_d = state_q;
        start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d = RUN;
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.opr_finished && !hazard_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (vld_d == {(NUM_STAGES-1){1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-program statistics, cleared when a new program starts.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (start_s) begin
            cycle_cnt_d = {CNT_W{1'b0}};
            stall_cnt_d = 16'd0;
        end else begin
            if (busy_s) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end else begin
                cycle_cnt_d = cycle_cnt_q;
            end
            if (hazard_s) begin
                stall_cnt_d = sat_inc16(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vld_q       <= {(NUM_STAGES-1){1'b0}};
            cycle_cnt_q <= {CNT_W{1'b0}};
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stage_en   = stage_en_s;
    assign bus.flush_ifid = br_s;
    assign bus.flush_idex = ld_use_s | br_s;
    assign bus.hazard     = hazard_s;
    assign bus.busy       = busy_s;
    assign bus.done       = (state_q == DONE);
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector tables plus randomized
// traffic compared against an instruction-tag occupancy model.
module tb_pipe_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    typedef struct {
        string      nm;
        logic [4:0] ctl;    // {rst, valid, fin, mem_read, br_taken}
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] en;
        logic [3:0] flg;    // {hazard, flush_ifid, flush_idex, done}
        int         ccyc;   // -1 = skip
        int         cstl;   // -1 = skip
        bit         chk;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; each stage holds an instruction tag or -1.
    int             m_phase;
    int             m_occ [1:4];
    int             m_tag;
    logic [CNT_W-1:0] m_cyc;
    logic [15:0]    m_stl;
    bit             m_hz;
    bit             m_br;
    vec_t           tbl[$];

    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input string nm, input logic [4:0] ctl, input logic [4:0] ert,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] en,
                                input logic [3:0] flg, input int ccyc, input int cstl);
        vec_t v;
        v.nm = nm; v.ctl = ctl; v.ert = ert; v.rs = rs; v.rt = rt;
        v.en = en; v.flg = flg; v.ccyc = ccyc; v.cstl = cstl; v.chk = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_check();
        bit v0, v1, v2, v3, v4, lu;
        v0 = (m_phase == 1);
        v1 = (m_occ[1] >= 0);
        v2 = (m_occ[2] >= 0);
        v3 = (m_occ[3] >= 0);
        v4 = (m_occ[4] >= 0);
        lu = v1 && v2 && bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
             ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        m_br = v2 && bus.ex_branch_taken;
        m_hz = lu && !m_br;
        check("model.stage_en",   64'(bus.stage_en),   64'({v4, v3, v2, v1 && !m_hz, v0 && !m_hz}));
        check("model.hazard",     64'(bus.hazard),     64'(m_hz));
        check("model.flush_ifid", 64'(bus.flush_ifid), 64'(m_br));
        check("model.flush_idex", 64'(bus.flush_idex), 64'(lu || m_br));
        check("model.busy",       64'(bus.busy),       64'(m_phase == 1 || m_phase == 2));
        check("model.done",       64'(bus.done),       64'(m_phase == 3));
        check("model.cycle_cnt",  64'(bus.cycle_cnt),  64'(m_cyc));
        check("model.stall_cnt",  64'(bus.stall_cnt),  64'(m_stl));
    endtask

    task automatic model_step();
        int n [1:4];
        bit empty;
        if (reset) begin
            m_phase = 0;
            for (int i = 1; i <= 4; i++) m_occ[i] = -1;
            m_cyc = '0;
            m_stl = '0;
        end else begin
            n[4] = m_occ[3];
            n[3] = m_occ[2];
            if (m_br) begin
                n[2] = -1; n[1] = -1;
            end else if (m_hz) begin
                n[2] = -1; n[1] = m_occ[1];
            end else begin
                n[2] = m_occ[1];
                if (m_phase == 1) begin n[1] = m_tag; m_tag++; end
                else n[1] = -1;
            end
            if (m_phase == 1 || m_phase == 2) m_cyc = m_cyc + 1'b1;
            if (m_hz && m_stl != 16'hFFFF) m_stl = m_stl + 1'b1;
            empty = (n[1] < 0) && (n[2] < 0) && (n[3] < 0) && (n[4] < 0);
            case (m_phase)
                0: if (bus.valid) begin m_phase = 1; m_cyc = '0; m_stl = '0; end
                1: if (bus.opr_finished && !m_hz) m_phase = 2;
                2: if (empty) m_phase = 3;
                default: m_phase = 0;
            endcase
            m_occ = n;
        end
    endtask

    task automatic apply(input vec_t v);
        reset               = v.ctl[4];
        bus.valid           = v.ctl[3];
        bus.opr_finished    = v.ctl[2];
        bus.ex_mem_read     = v.ctl[1];
        bus.ex_branch_taken = v.ctl[0];
        bus.ex_rt           = v.ert;
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        #2;
        model_check();
        if (v.chk) begin
            check({v.nm, ".stage_en"},   64'(bus.stage_en),   64'(v.en));
            check({v.nm, ".hazard"},     64'(bus.hazard),     64'(v.flg[3]));
            check({v.nm, ".flush_ifid"}, 64'(bus.flush_ifid), 64'(v.flg[2]));
            check({v.nm, ".flush_idex"}, 64'(bus.flush_idex), 64'(v.flg[1]));
            check({v.nm, ".done"},       64'(bus.done),       64'(v.flg[0]));
            if (v.ccyc >= 0) check({v.nm, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'(v.ccyc));
            if (v.cstl >= 0) check({v.nm, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(v.cstl));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Three instructions, finish at cycle 3; c3 inputs vary to cover the ex_rt==0 case.
    task automatic add_basic(input string nm, input logic [4:0] c3ctl, input logic [4:0] c3rs);
        tbl.push_back(mk(nm, 5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00001, 4'b0000,  0,  0));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00011, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, c3ctl,    5'd0, c3rs, 5'd0, 5'b00111, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b01110, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b11100, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b10000, 4'b0000, -1, -1));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0001,  7,  0));
        tbl.push_back(mk(nm, 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
    endtask

    initial begin
        vec_t rv;
        bus.valid = 1'b0; bus.opr_finished = 1'b0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        m_phase = 0; m_tag = 0; m_cyc = '0; m_stl = '0; m_hz = 1'b0; m_br = 1'b0;
        for (int i = 1; i <= 4; i++) m_occ[i] = -1;
        @(posedge clk);
        #1;

        tbl.push_back(mk("reset", 5'b10000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, 0, 0));
        tbl.push_back(mk("reset", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, 0, 0));
        add_basic("basic3", 5'b00100, 5'd0);
        add_basic("ldrt0",  5'b00110, 5'd3);

        // Load-use at cycle 3: one stall, finish re-presented, done slips to cycle 9.
        tbl.push_back(mk("lduse", 5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00001, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00011, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00110, 5'd5, 5'd5, 5'd2, 5'b00100, 4'b1010, -1,  0));
        tbl.push_back(mk("lduse", 5'b00100, 5'd0, 5'd0, 5'd0, 5'b01011, 4'b0000, -1,  1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b10110, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b01100, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b10000, 4'b0000, -1, -1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0001,  8,  1));
        tbl.push_back(mk("lduse", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));

        // Taken branch at cycle 3 squashes ID/EX; fetch continues.
        tbl.push_back(mk("branch", 5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00001, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00011, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00001, 5'd0, 5'd0, 5'd0, 5'b00111, 4'b0110, -1, -1));
        tbl.push_back(mk("branch", 5'b00100, 5'd0, 5'd0, 5'd0, 5'b01001, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b10010, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00100, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b01000, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b10000, 4'b0000, -1, -1));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0001,  8,  0));
        tbl.push_back(mk("branch", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));

        // Branch, load-use and finish in one cycle: branch wins, no stall, DRAIN entered.
        tbl.push_back(mk("br_ld", 5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("br_ld", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00001, 4'b0000, -1, -1));
        tbl.push_back(mk("br_ld", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00011, 4'b0000, -1, -1));
        tbl.push_back(mk("br_ld", 5'b00111, 5'd5, 5'd5, 5'd0, 5'b00111, 4'b0110, -1,  0));
        tbl.push_back(mk("br_ld", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b01000, 4'b0000, -1,  0));
        tbl.push_back(mk("br_ld", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b10000, 4'b0000, -1, -1));
        tbl.push_back(mk("br_ld", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0001,  5,  0));
        tbl.push_back(mk("br_ld", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));

        // Reset while draining with vld=01100 aborts silently; a later start runs cleanly.
        tbl.push_back(mk("rstdrain", 5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("rstdrain", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00001, 4'b0000, -1, -1));
        tbl.push_back(mk("rstdrain", 5'b00100, 5'd0, 5'd0, 5'd0, 5'b00011, 4'b0000, -1, -1));
        tbl.push_back(mk("rstdrain", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00110, 4'b0000, -1, -1));
        tbl.push_back(mk("rstdrain", 5'b10000, 5'd0, 5'd0, 5'd0, 5'b01100, 4'b0000,  3, -1));
        tbl.push_back(mk("rstdrain", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000,  0,  0));
        tbl.push_back(mk("rstdrain", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("rstdrain", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("restart",  5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));
        tbl.push_back(mk("restart",  5'b00100, 5'd0, 5'd0, 5'd0, 5'b00001, 4'b0000,  0,  0));
        tbl.push_back(mk("restart",  5'b00000, 5'd0, 5'd0, 5'd0, 5'b00010, 4'b0000, -1, -1));
        tbl.push_back(mk("restart",  5'b00000, 5'd0, 5'd0, 5'd0, 5'b00100, 4'b0000, -1, -1));
        tbl.push_back(mk("restart",  5'b00000, 5'd0, 5'd0, 5'd0, 5'b01000, 4'b0000, -1, -1));
        tbl.push_back(mk("restart",  5'b00000, 5'd0, 5'd0, 5'd0, 5'b10000, 4'b0000, -1, -1));
        tbl.push_back(mk("restart",  5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0001,  5,  0));
        tbl.push_back(mk("restart",  5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1));

        foreach (tbl[i]) apply(tbl[i]);

        // Randomized traffic: small register range so load-use matches are frequent.
        for (int k = 0; k < 4000; k++) begin
            rv = mk("rand", 5'b00000, 5'd0, 5'd0, 5'd0, 5'b00000, 4'b0000, -1, -1);
            rv.chk    = 1'b0;
            rv.ctl[4] = ($urandom_range(0, 199) == 0);
            rv.ctl[3] = ($urandom_range(0, 3) == 0);
            rv.ctl[2] = ($urandom_range(0, 5) == 0);
            rv.ctl[1] = $urandom_range(0, 1) != 0;
            rv.ctl[0] = ($urandom_range(0, 7) == 0);
            rv.ert    = 5'($urandom_range(0, 3));
            rv.rs     = 5'($urandom_range(0, 3));
            rv.rt     = 5'($urandom_range(0, 3));
            apply(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
